mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single 256-bit data-memory port between the instruction-cache and data-cache refill/write-back controllers. It sits between the two cache controllers and the off-chip data memory. The memory sees one requester at a time. Each cache keeps its existing enable/ack handshake.

## Interface
Parameters:
- DATA_W, 256, memory line width in bits
- ADDR_W, 32, byte address width

Ports:
- clk_i  in  1  system clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- m0_enable_i  in  1  port 0 (data cache) request, level, held until m0_ack_o
- m0_write_i  in  1  port 0: 1 = write line, 0 = read line
- m0_addr_i  in  ADDR_W  port 0 line address
- m0_data_i  in  DATA_W  port 0 write data
- m0_data_o  out  DATA_W  port 0 read data, registered
- m0_ack_o  out  1  port 0 completion, one-cycle pulse
- m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o: same as port 0, for port 1 (instruction cache)
- mem_enable_o  out  1  request to data memory
- mem_write_o  out  1  write strobe to data memory
- mem_addr_o  out  ADDR_W  address to data memory
- mem_data_o  out  DATA_W  write data to data memory
- mem_data_i  in  DATA_W  read data from data memory, valid with mem_ack_i
- mem_ack_i  in  1  data memory completion, one-cycle pulse
- grant_o  out  2  one-hot current owner; 00 when idle

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If no mN_enable_i is high, stay in IDLE.
  - If only one port requests, grant that port.
  - If both ports request, grant the port that is not last_grant (round-robin).
  - On a grant, on the same edge:
    - latch the granted port's addr, write and data into the mem_* output registers
    - set grant_o
    - set last_grant
    - go to BUSY
- **BUSY**
  - mem_enable_o = 1.
  - mem_addr_o, mem_write_o and mem_data_o hold their latched values. Later changes on the requester's inputs are ignored.
  - When mem_ack_i is sampled high:
    - if the transaction is a read, capture mem_data_i into the granted mN_data_o register
    - go to DONE
- **DONE**
  - mem_enable_o = 0.
  - mN_ack_o = 1 for the granted port only.
  - grant_o stays at the same value.
  - Always go to IDLE next; requests are not sampled in DONE.
- mN_data_o holds its value until the next read ack to that port. Write acks leave it unchanged.
- mem_ack_i is ignored in IDLE and DONE.
- If the requester drops mN_enable_i during BUSY, the transaction still completes and the ack is still pulsed.
- last_grant resets to port 1, so port 0 wins the first tie.

## Timing
- Reset values: mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, m0/m1_data_o=0, m0/m1_ack_o=0, grant_o=00, state=IDLE, last_grant=1.
- Reset asserted mid-transaction: IDLE on the next edge, mem_enable_o low, no ack emitted. The aborted request is lost.
- Cycle timeline for one transaction:
  - Request sampled in IDLE at edge e0.
  - mem_enable_o high from the cycle after e0.
  - mem_ack_i sampled high at edge eA.
  - mN_ack_o high for exactly the cycle after eA, with mN_data_o already valid in that cycle.
  - IDLE one cycle later.
- Arbiter overhead is 2 cycles beyond memory latency: one grant cycle plus one DONE cycle.
- Back-to-back requests: minimum 3 cycles between the mem_ack_i pulse and the next mem_enable_o rise (DONE, IDLE, then BUSY).
- No port is starved: with both ports requesting continuously, grants alternate 0,1,0,1.

## Test plan
- Port 0 reads alone, addr 0x0000_0400, memory ack after 10 cycles with data 256'hA5…A5.
  - Required: mem_enable_o high for 10 cycles.
  - Required: m0_ack_o pulses one cycle later with m0_data_o=256'hA5…A5.
  - Required: m1_ack_o stays 0 and m1_data_o stays 0.
- Both ports request in the same cycle out of reset; port 0 writes 0x100, port 1 reads 0x200.
  - Required: port 0 is served first (mem_write_o=1, addr 0x100), then port 1 (addr 0x200).
  - Required: grant_o sequence 01 then 10.
- Both ports hold requests for 4 transactions.
  - Required: grants alternate 0,1,0,1.
  - Required: each mN_ack_o pulses exactly twice.
- Port 1 changes m1_addr_i from 0x300 to 0x340 during BUSY.
  - Required: mem_addr_o stays 0x300 until DONE.
- Stray and write-ack behaviour:
  - Stray mem_ack_i in IDLE: no mN_ack_o, state stays IDLE.
  - After a read of 0xDEAD… to port 0, a port 0 write ack leaves m0_data_o=0xDEAD….
- rst_i pulsed for one cycle in the middle of BUSY.
  - Required: all outputs at their reset values on the next cycle.
  - Required: no ack is pulsed.
  - Required: a fresh request afterwards completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide data-memory port between the
// data-cache (port 0) and instruction-cache (port 1) controllers.
module mem_arbiter #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,

    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,

    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;   // 1 = port 1 was served last
    logic [1:0] grant_nxt;

    always_comb begin
        state_nxt = state;
        grant_nxt = '0;
        case (state)
            IDLE: begin
                // On a tie the port that was not served last wins.
                if (m0_enable_i && m1_enable_i) begin
                    grant_nxt = last_grant ? 2'b01 : 2'b10;
                end else if (m0_enable_i) begin
                    grant_nxt = 2'b01;
                end else if (m1_enable_i) begin
                    grant_nxt = 2'b10;
                end
                if (grant_nxt != 2'b00) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant_o     <= '0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            m0_data_o   <= '0;
            m1_data_o   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_nxt != 2'b00) begin
                        grant_o    <= grant_nxt;
                        last_grant <= grant_nxt[1];
                        if (grant_nxt[1]) begin
                            mem_write_o <= m1_write_i;
                            mem_addr_o  <= m1_addr_i;
                            mem_data_o  <= m1_data_i;
                        end else begin
                            mem_write_o <= m0_write_i;
                            mem_addr_o  <= m0_addr_i;
                            mem_data_o  <= m0_data_i;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack_i && !mem_write_o) begin
                        if (grant_o[1]) begin
                            m1_data_o <= mem_data_i;
                        end else begin
                            m0_data_o <= mem_data_i;
                        end
                    end
                end
                DONE: begin
                    grant_o <= '0;
                end
                default: begin
                    grant_o <= '0;
                end
            endcase
        end
    end

    assign mem_enable_o = (state == BUSY);
    assign m0_ack_o     = (state == DONE) && grant_o[0];
    assign m1_ack_o     = (state == DONE) && grant_o[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a latency-programmable memory stub plus
// expected-ack / expected-transaction queues compared against observed ones.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int DW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [DW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o;
    logic          m0_ack_o, m1_ack_o;
    logic          mem_enable_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o, mem_data_i;
    logic          mem_ack_i, resp_ack, stray_ack;
    logic [1:0]    grant_o;

    assign mem_ack_i = resp_ack | stray_ack;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .grant_o(grant_o)
    );

    typedef struct packed {
        logic [1:0]    acks;
        logic [1:0]    grant;
        logic [DW-1:0] data;
    } ack_t;

    typedef struct packed {
        logic [1:0]    grant;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    ack_t ack_exp[$], ack_obs[$];
    txn_t txn_exp[$], txn_obs[$];
    logic [DW-1:0] tb_mem [logic [AW-1:0]];

    int total = 0;
    int bad = 0;
    int mem_lat = 3;
    int ack0_cnt = 0;
    int ack1_cnt = 0;
    logic [DW-1:0] exp_d0, exp_d1;
    logic [DW-1:0] pat_a5, pat_dead;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (tb_mem.exists(a)) return tb_mem[a];
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    // Memory stub: acks mem_lat cycles after it first sees mem_enable_o.
    initial begin : responder
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] d;
        logic [31:0]   r;
        bit            aborted;
        resp_ack   = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            if (mem_enable_o === 1'b1) begin
                a = mem_addr_o; w = mem_write_o; d = mem_data_o; aborted = 0;
                for (int i = 1; i < mem_lat; i++) begin
                    @(negedge clk);
                    if (mem_enable_o !== 1'b1) begin
                        aborted = 1;
                        break;
                    end
                end
                if (!aborted) begin
                    if (w) begin
                        tb_mem[a]  = d;
                        mem_data_i = {8{32'hBAD0_0BAD}};
                    end else begin
                        mem_data_i = mem_val(a);
                    end
                    resp_ack = 1'b1;
                    @(negedge clk);
                    resp_ack = 1'b0;
                    r = $urandom;
                    mem_data_i = {8{r}};
                end
            end
        end
    end

    initial begin : monitor
        ack_t e;
        txn_t t;
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (m0_ack_o === 1'b1 || m1_ack_o === 1'b1) begin
                e.acks  = {m1_ack_o, m0_ack_o};
                e.grant = grant_o;
                e.data  = (m1_ack_o === 1'b1) ? m1_data_o : m0_data_o;
                ack_obs.push_back(e);
            end
            if (m0_ack_o === 1'b1) ack0_cnt++;
            if (m1_ack_o === 1'b1) ack1_cnt++;
            if (mem_enable_o === 1'b1 && !prev_en) begin
                t.grant = grant_o; t.wr = mem_write_o; t.addr = mem_addr_o; t.data = mem_data_o;
                txn_obs.push_back(t);
            end
            prev_en = (mem_enable_o === 1'b1);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_enable_i = 0; m0_write_i = 0; m0_addr_i = '0; m0_data_i = '0;
        m1_enable_i = 0; m1_write_i = 0; m1_addr_i = '0; m1_data_i = '0;
        stray_ack = 0;
        tick();
        tick();
        rst = 1'b0;
        ack_obs.delete(); ack_exp.delete(); txn_obs.delete(); txn_exp.delete();
        exp_d0 = '0; exp_d1 = '0;
    endtask

    // Drives one request and holds it until its ack; ok=0 on timeout.
    task automatic run_one(input bit port, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, output bit ok);
        ok = 0;
        if (port) begin
            m1_enable_i = 1; m1_write_i = wr; m1_addr_i = addr; m1_data_i = data;
        end else begin
            m0_enable_i = 1; m0_write_i = wr; m0_addr_i = addr; m0_data_i = data;
        end
        for (int c = 0; c < 100; c++) begin
            tick();
            if ((port ? m1_ack_o : m0_ack_o) === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (port) m1_enable_i = 0; else m0_enable_i = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_enable_i = 1; m1_enable_i = 1; stray_ack = 0;
        m0_write_i = 1; m0_addr_i = 32'h1234; m0_data_i = '1;
        m1_write_i = 0; m1_addr_i = 32'h5678; m1_data_i = '1;
        tick();
        tick();
        total++; if (mem_enable_o !== 1'b0) begin bad++; $display("FAIL reset_mem_enable got=%b exp=0", mem_enable_o); end
        total++; if (mem_write_o !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%b exp=0", mem_write_o); end
        total++; if (mem_addr_o !== '0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr_o); end
        total++; if (mem_data_o !== '0) begin bad++; $display("FAIL reset_mem_data got=%h exp=0", mem_data_o); end
        total++; if ({m1_ack_o, m0_ack_o} !== 2'b00) begin bad++; $display("FAIL reset_acks got=%b exp=00", {m1_ack_o, m0_ack_o}); end
        total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant_o); end
        total++; if (m0_data_o !== '0 || m1_data_o !== '0) begin bad++; $display("FAIL reset_port_data got=%h/%h exp=0", m0_data_o, m1_data_o); end
        do_reset();
        total++; if (mem_enable_o !== 1'b0 || grant_o !== 2'b00) begin bad++; $display("FAIL reset_idle got en=%b grant=%b exp en=0 grant=00", mem_enable_o, grant_o); end
    endtask

    task automatic test_single_read();
        ack_t e, o;
        int en_cnt = 0;
        bit done = 0, p1_bad = 0;
        tb_mem[32'h400] = pat_a5;
        e.acks = 2'b01; e.grant = 2'b01; e.data = pat_a5;
        ack_exp.push_back(e);
        exp_d0 = pat_a5;
        mem_lat = 10;
        m0_addr_i = 32'h0000_0400; m0_write_i = 0; m0_data_i = '0; m0_enable_i = 1;
        for (int c = 0; c < 60 && !done; c++) begin
            tick();
            if (mem_enable_o === 1'b1) en_cnt++;
            if (m1_ack_o !== 1'b0 || m1_data_o !== '0) p1_bad = 1;
            if (m0_ack_o === 1'b1) begin
                done = 1;
                m0_enable_i = 0;
            end
        end
        total++; if (!done) begin bad++; $display("FAIL single_timeout got=no_ack exp=ack"); end
        total++; if (en_cnt != 10) begin bad++; $display("FAIL single_enable_cycles got=%0d exp=10", en_cnt); end
        total++; if (p1_bad) begin bad++; $display("FAIL single_port1_quiet got=activity exp=none"); end
        while (ack_exp.size() > 0) begin
            e = ack_exp.pop_front();
            total++;
            if (ack_obs.size() == 0) begin bad++; $display("FAIL single_ack got=missing exp=%h", e); end
            else begin
                o = ack_obs.pop_front();
                if (o !== e) begin bad++; $display("FAIL single_ack got=%h exp=%h", o, e); end
            end
        end
        tick();
        total++; if (m0_ack_o !== 1'b0 || grant_o !== 2'b00) begin bad++; $display("FAIL single_after got ack=%b grant=%b exp ack=0 grant=00", m0_ack_o, grant_o); end
        total++; if (m0_data_o !== exp_d0) begin bad++; $display("FAIL single_hold got=%h exp=%h", m0_data_o, exp_d0); end
    endtask

    task automatic test_tie();
        ack_t e, o;
        txn_t t, u;
        logic [DW-1:0] w0, d1;
        do_reset();
        w0 = {4{64'h0123_4567_89AB_CDEF}};
        d1 = {4{64'h1111_2222_3333_4444}};
        mem_lat = 2;
        t.grant = 2'b01; t.wr = 1; t.addr = 32'h100; t.data = w0; txn_exp.push_back(t);
        t.grant = 2'b10; t.wr = 0; t.addr = 32'h200; t.data = d1; txn_exp.push_back(t);
        e.acks = 2'b01; e.grant = 2'b01; e.data = '0; ack_exp.push_back(e);
        exp_d1 = mem_val(32'h200);
        e.acks = 2'b10; e.grant = 2'b10; e.data = exp_d1; ack_exp.push_back(e);
        m0_enable_i = 1; m0_write_i = 1; m0_addr_i = 32'h100; m0_data_i = w0;
        m1_enable_i = 1; m1_write_i = 0; m1_addr_i = 32'h200; m1_data_i = d1;
        for (int c = 0; c < 60 && (m0_enable_i || m1_enable_i); c++) begin
            tick();
            if (m0_ack_o === 1'b1) m0_enable_i = 0;
            if (m1_ack_o === 1'b1) m1_enable_i = 0;
        end
        total++; if (m0_enable_i || m1_enable_i) begin bad++; $display("FAIL tie_timeout got=pending exp=both_acked"); end
        m0_enable_i = 0; m1_enable_i = 0;
        while (txn_exp.size() > 0) begin
            t = txn_exp.pop_front();
            total++;
            if (txn_obs.size() == 0) begin bad++; $display("FAIL tie_txn got=missing exp=%h", t); end
            else begin
                u = txn_obs.pop_front();
                if (u !== t) begin bad++; $display("FAIL tie_txn got=%h exp=%h", u, t); end
            end
        end
        while (ack_exp.size() > 0) begin
            e = ack_exp.pop_front();
            total++;
            if (ack_obs.size() == 0) begin bad++; $display("FAIL tie_ack got=missing exp=%h", e); end
            else begin
                o = ack_obs.pop_front();
                if (o !== e) begin bad++; $display("FAIL tie_ack got=%h exp=%h", o, e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        ack_t e, o;
        txn_t t, u;
        logic [AW-1:0] a0 [4];
        logic [1:0]    g  [4];
        logic [DW-1:0] d0, d1;
        int base0, base1, acks = 0, cyc = 0, last_ack = -1;
        bit prev_en = 0;
        a0 = '{32'h1000, 32'h2000, 32'h1040, 32'h2040};
        g  = '{2'b01, 2'b10, 2'b01, 2'b10};
        d0 = {8{32'hD0D0_0000}};
        d1 = {8{32'hD1D1_1111}};
        txn_obs.delete();
        base0 = ack0_cnt; base1 = ack1_cnt;
        mem_lat = $urandom_range(1, 4);
        for (int i = 0; i < 4; i++) begin
            t.grant = g[i]; t.wr = 0; t.addr = a0[i]; t.data = g[i][1] ? d1 : d0;
            txn_exp.push_back(t);
            e.acks = g[i]; e.grant = g[i]; e.data = mem_val(a0[i]);
            ack_exp.push_back(e);
        end
        exp_d0 = mem_val(32'h1040);
        exp_d1 = mem_val(32'h2040);
        m0_enable_i = 1; m0_write_i = 0; m0_addr_i = 32'h1000; m0_data_i = d0;
        m1_enable_i = 1; m1_write_i = 0; m1_addr_i = 32'h2000; m1_data_i = d1;
        for (int c = 0; c < 200 && acks < 4; c++) begin
            tick();
            cyc++;
            if (resp_ack === 1'b1) last_ack = cyc;
            if (mem_enable_o === 1'b1 && !prev_en && last_ack >= 0) begin
                total++;
                if (cyc - last_ack != 3) begin bad++; $display("FAIL b2b_gap got=%0d exp=3", cyc - last_ack); end
            end
            prev_en = (mem_enable_o === 1'b1);
            if (m0_ack_o === 1'b1) begin acks++; m0_addr_i = 32'h1040; end
            if (m1_ack_o === 1'b1) begin acks++; m1_addr_i = 32'h2040; end
        end
        m0_enable_i = 0; m1_enable_i = 0;
        total++; if (acks != 4) begin bad++; $display("FAIL b2b_timeout got=%0d exp=4", acks); end
        tick();
        total++; if (ack0_cnt - base0 != 2 || ack1_cnt - base1 != 2) begin bad++; $display("FAIL b2b_ack_counts got=%0d/%0d exp=2/2", ack0_cnt - base0, ack1_cnt - base1); end
        while (txn_exp.size() > 0) begin
            t = txn_exp.pop_front();
            total++;
            if (txn_obs.size() == 0) begin bad++; $display("FAIL b2b_txn got=missing exp=%h", t); end
            else begin
                u = txn_obs.pop_front();
                if (u !== t) begin bad++; $display("FAIL b2b_txn got=%h exp=%h", u, t); end
            end
        end
        while (ack_exp.size() > 0) begin
            e = ack_exp.pop_front();
            total++;
            if (ack_obs.size() == 0) begin bad++; $display("FAIL b2b_ack got=missing exp=%h", e); end
            else begin
                o = ack_obs.pop_front();
                if (o !== e) begin bad++; $display("FAIL b2b_ack got=%h exp=%h", o, e); end
            end
        end
    endtask

    task automatic test_addr_hold();
        ack_t e, o;
        int busy = 0;
        bit done = 0, held_bad = 0;
        logic [AW-1:0] bad_addr = '0;
        mem_lat = 6;
        exp_d1 = mem_val(32'h300);
        e.acks = 2'b10; e.grant = 2'b10; e.data = exp_d1; ack_exp.push_back(e);
        m1_enable_i = 1; m1_write_i = 0; m1_addr_i = 32'h300; m1_data_i = '0;
        for (int c = 0; c < 60 && !done; c++) begin
            tick();
            if (mem_enable_o === 1'b1) begin
                busy++;
                if (busy == 2) begin
                    m1_addr_i = 32'h340; m1_write_i = 1; m1_data_i = '1;
                end
            end
            if (mem_enable_o === 1'b1 || m1_ack_o === 1'b1) begin
                if (mem_addr_o !== 32'h300 || mem_write_o !== 1'b0) begin
                    held_bad = 1; bad_addr = mem_addr_o;
                end
            end
            if (m1_ack_o === 1'b1) begin
                done = 1;
                m1_enable_i = 0;
            end
        end
        m1_enable_i = 0; m1_write_i = 0;
        total++; if (!done) begin bad++; $display("FAIL hold_timeout got=no_ack exp=ack"); end
        total++; if (held_bad) begin bad++; $display("FAIL hold_addr got=%h exp=00000300", bad_addr); end
        while (ack_exp.size() > 0) begin
            e = ack_exp.pop_front();
            total++;
            if (ack_obs.size() == 0) begin bad++; $display("FAIL hold_ack got=missing exp=%h", e); end
            else begin
                o = ack_obs.pop_front();
                if (o !== e) begin bad++; $display("FAIL hold_ack got=%h exp=%h", o, e); end
            end
        end
    endtask

    task automatic test_stray_ack();
        tick();
        stray_ack = 1;
        tick();
        stray_ack = 0;
        total++; if ({m1_ack_o, m0_ack_o} !== 2'b00) begin bad++; $display("FAIL stray_acks got=%b exp=00", {m1_ack_o, m0_ack_o}); end
        total++; if (grant_o !== 2'b00 || mem_enable_o !== 1'b0) begin bad++; $display("FAIL stray_state got grant=%b en=%b exp grant=00 en=0", grant_o, mem_enable_o); end
        tick();
        tick();
        total++; if (mem_enable_o !== 1'b0 || ack_obs.size() != 0) begin bad++; $display("FAIL stray_idle got en=%b acks=%0d exp en=0 acks=0", mem_enable_o, ack_obs.size()); end
        total++; if (m0_data_o !== exp_d0 || m1_data_o !== exp_d1) begin bad++; $display("FAIL stray_data got=%h exp=%h", m0_data_o, exp_d0); end
    endtask

    task automatic test_write_keeps_data();
        ack_t e, o;
        bit ok1, ok2;
        tb_mem[32'h500] = pat_dead;
        mem_lat = 2;
        e.acks = 2'b01; e.grant = 2'b01; e.data = pat_dead;
        ack_exp.push_back(e);
        ack_exp.push_back(e);
        exp_d0 = pat_dead;
        run_one(1'b0, 1'b0, 32'h500, '0, ok1);
        tick();
        run_one(1'b0, 1'b1, 32'h600, {8{32'hCAFE_F00D}}, ok2);
        total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL wr_timeout got=%0b%0b exp=11", ok1, ok2); end
        tick();
        total++; if (m0_data_o !== pat_dead) begin bad++; $display("FAIL wr_keeps_data got=%h exp=%h", m0_data_o, pat_dead); end
        while (ack_exp.size() > 0) begin
            e = ack_exp.pop_front();
            total++;
            if (ack_obs.size() == 0) begin bad++; $display("FAIL wr_ack got=missing exp=%h", e); end
            else begin
                o = ack_obs.pop_front();
                if (o !== e) begin bad++; $display("FAIL wr_ack got=%h exp=%h", o, e); end
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        ack_t e, o;
        bit seen = 0, ok;
        int base0, base1;
        mem_lat = 10;
        m1_enable_i = 1; m1_write_i = 0; m1_addr_i = 32'h700; m1_data_i = {8{32'h7777_7777}};
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (mem_enable_o === 1'b1) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL rstbusy_start got=no_enable exp=enable"); end
        tick();
        tick();
        rst = 1; m1_enable_i = 0;
        tick();
        total++; if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 || mem_addr_o !== '0 || mem_data_o !== '0) begin
            bad++; $display("FAIL rstbusy_mem got en=%b wr=%b addr=%h exp 0/0/0", mem_enable_o, mem_write_o, mem_addr_o);
        end
        total++; if (grant_o !== 2'b00 || {m1_ack_o, m0_ack_o} !== 2'b00) begin bad++; $display("FAIL rstbusy_ctrl got grant=%b acks=%b exp 00/00", grant_o, {m1_ack_o, m0_ack_o}); end
        total++; if (m0_data_o !== '0 || m1_data_o !== '0) begin bad++; $display("FAIL rstbusy_data got=%h/%h exp=0", m0_data_o, m1_data_o); end
        rst = 0;
        exp_d0 = '0; exp_d1 = '0;
        base0 = ack0_cnt; base1 = ack1_cnt;
        for (int c = 0; c < 15; c++) tick();
        total++; if (ack0_cnt != base0 || ack1_cnt != base1 || ack_obs.size() != 0) begin bad++; $display("FAIL rstbusy_no_ack got=%0d acks exp=0", ack_obs.size()); end
        ack_obs.delete();
        exp_d1 = mem_val(32'h700);
        e.acks = 2'b10; e.grant = 2'b10; e.data = exp_d1; ack_exp.push_back(e);
        mem_lat = 3;
        run_one(1'b1, 1'b0, 32'h700, '0, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstbusy_recover got=no_ack exp=ack"); end
        while (ack_exp.size() > 0) begin
            e = ack_exp.pop_front();
            total++;
            if (ack_obs.size() == 0) begin bad++; $display("FAIL rstbusy_ack got=missing exp=%h", e); end
            else begin
                o = ack_obs.pop_front();
                if (o !== e) begin bad++; $display("FAIL rstbusy_ack got=%h exp=%h", o, e); end
            end
        end
    endtask

    initial begin
        logic [7:0]  a5;
        logic [31:0] dead;
        a5 = 8'hA5;
        dead = 32'hDEAD_BEEF;
        pat_a5 = {32{a5}};
        pat_dead = {8{dead}};
        stray_ack = 0;
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_addr_hold();
        test_stray_ack();
        test_write_keeps_data();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
